// File: rtl/text_uart_tx.sv
// -----------------------------------------------------------------------------
// text_uart_tx
//
// Last stage of the text link before the board's serial pin. Decrypted 7-bit
// characters arrive on a valid/ready handshake, are buffered in a small FIFO,
// and are serialised LSB first in a fixed 10-bit frame:
//   start(0), data[0]..data[6], bit 8, stop(1)
// Bit 8 is 0 (8N1 with MSB 0) unless TEXT_PARITY_EN is defined, in which case
// it carries even parity over the character (7E1). Frame length and timing
// are identical in both builds.
//
// Build option:
//   TEXT_PARITY_EN  - when defined, bit 8 of every frame is ^data.
//
// Parameters:
//   n             character width, only 7 is meaningful for the 10-bit frame
//   DEPTH         FIFO depth in characters, power of 2, >= 2
//   CLKS_PER_BIT  clk cycles per UART bit, >= 2
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   data_in     character from the decrypt stage
//   in_valid    data_in holds a character this cycle
//   in_ready    FIFO has room (registered count < DEPTH)
//   tx          UART line, idles high, registered
//   busy        a frame is in progress
//   fifo_count  characters currently buffered
//   overflow    sticky: a write was attempted while in_ready was low
// -----------------------------------------------------------------------------
module text_uart_tx #(
  parameter int n            = 7,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n-1:0]           data_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [n-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          overflow_reg;

  // Serialiser
  state_t        state_reg;
  logic [BW-1:0] baud_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic          busy_reg;

  logic          push;
  logic          pop;
  logic          frame_end;
  logic [n-1:0]  head;
  logic [7:0]    payload;

  assign in_ready   = (count_reg < FULL_COUNT);
  assign push       = in_valid && in_ready;
  assign frame_end  = (state_reg == S_STOP) && (baud_reg == BAUD_LAST);
  // A new frame is loaded either from idle or straight out of a stop bit,
  // which is what makes back-to-back frames gapless.
  assign pop        = (count_reg != '0) && ((state_reg == S_IDLE) || frame_end);
  assign head       = mem[rd_ptr_reg];

  // The 8 bits clocked out during the DATA state: character then bit 8.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_payload
      assign payload[gi] = head[gi];
    end
  endgenerate

`ifdef TEXT_PARITY_EN
  assign payload[7] = ^head[6:0];
`else
  assign payload[7] = 1'b0;
`endif

  // FIFO write port. The array is left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (in_valid && !in_ready) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Frame FSM. tx is registered and always holds the level of the bit the
  // FSM is currently in, so each transition also loads the next line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          baud_reg <= '0;
          tx_reg   <= 1'b1;
          if (pop) begin
            state_reg <= S_START;
            shift_reg <= payload;
            tx_reg    <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end

        S_START: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            state_reg   <= S_DATA;
            tx_reg      <= shift_reg[0];
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= S_STOP;
              tx_reg    <= 1'b1;
            end else begin
              // Shift right so the next bit to send is always at [0].
              bit_idx_reg <= bit_idx_reg + 3'd1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        S_STOP: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg <= '0;
            if (pop) begin
              state_reg <= S_START;
              shift_reg <= payload;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= S_IDLE;
              tx_reg    <= 1'b1;
              busy_reg  <= 1'b0;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          baud_reg  <= '0;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_text_uart_tx.sv
// -----------------------------------------------------------------------------
// Bench for text_uart_tx with CLKS_PER_BIT=4, DEPTH=8.
// A cycle-level behavioural model (character queue plus a "cycles left in the
// current frame" counter) predicts tx/busy/fifo_count/in_ready/overflow every
// cycle, and a line decoder rebuilds characters from tx for order checks.
// -----------------------------------------------------------------------------
module tb_text_uart_tx;

  localparam int C = 4;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  text_uart_tx #(
    .n(7),
    .DEPTH(D),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic bit8(input logic [6:0] d);
`ifdef TEXT_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  logic [6:0] m_q[$];
  logic [6:0] m_acc[$];
  logic [6:0] m_cur = '0;
  int         m_rem = 0;
  bit         m_ovf = 1'b0;
  bit         m_take;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      m_take = in_valid && (m_q.size() < D);
      if (in_valid && !m_take) m_ovf = 1'b1;
      if (m_rem > 0) m_rem--;
      if (m_rem == 0 && m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_rem = 10 * C;
      end
      if (m_take) begin
        m_q.push_back(data_in);
        m_acc.push_back(data_in);
      end
    end
  end

  function automatic logic model_tx();
    logic [9:0] f;
    int idx;
    if (m_rem == 0) return 1'b1;
    f   = {1'b1, bit8(m_cur), m_cur, 1'b0};
    idx = (10 * C - m_rem) / C;
    return f[idx];
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_tx",         tx,         model_tx());
      chk("cyc_busy",       busy,       m_rem != 0);
      chk("cyc_fifo_count", fifo_count, m_q.size());
      chk("cyc_in_ready",   in_ready,   m_q.size() < D);
      chk("cyc_overflow",   overflow,   m_ovf);
    end
  end

  // ---------------- line decoder ----------------
  logic [6:0] rx_q[$];
  bit         dec_on = 1'b0;
  int         dec_cnt = 0;
  logic [9:0] dec_bits;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      dec_on = 1'b0;
    end else if (!dec_on) begin
      if (tx === 1'b0) begin
        dec_on  = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % C == C / 2) dec_bits[dec_cnt / C] = tx;
      if (dec_cnt == 9 * C + C / 2) begin
        rx_q.push_back(dec_bits[7:1]);
        dec_on = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input int max_cycles, input string tag);
    int n_cyc = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || fifo_count !== 4'd0) && n_cyc < max_cycles) begin
      @(negedge clk);
      n_cyc++;
    end
    if (n_cyc >= max_cycles) chk(tag, {busy, fifo_count}, 5'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] d);
    data_in  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  logic [6:0] exp_q[$];
  logic [9:0] frame;
  int         bcnt;
  logic [6:0] d;

  initial begin
    in_valid = 1'b0;
    data_in  = '0;
    rst      = 1'b1;
    #2 rst   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst   = 1'b1;
    check_en = 1'b1;
    chk("rst_tx",         tx,         1'b1);
    chk("rst_busy",       busy,       1'b0);
    chk("rst_in_ready",   in_ready,   1'b1);
    chk("rst_fifo_count", fifo_count, 4'd0);
    chk("rst_overflow",   overflow,   1'b0);
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bcnt++;
    end
    chk("idle_tx_low_cycles", bcnt, 0);

    // Single character, exact bit timing
    @(posedge clk); #1;
    put(7'h43);
    in_valid = 1'b0;
    chk("single_count_after_write", fifo_count, 4'd1);
    @(posedge clk);
    frame = {1'b1, bit8(7'h43), 7'h43, 1'b0};
    bcnt  = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i < 40) chk($sformatf("single_tx_c%0d", i), tx, frame[i / C]);
      if (busy) bcnt++;
    end
    chk("single_busy_cycles", bcnt, 40);
    chk("single_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("single_rx_char", rx_q.pop_front(), 7'h43);
    rx_q.delete();

    // Fill past capacity
    for (int i = 0; i < 10; i++) begin
      data_in  = 7'h30 + 7'(i);
      in_valid = 1'b1;
      if (i == 9) begin
        chk("fill_count_full", fifo_count, 4'd8);
        chk("fill_in_ready_low", in_ready, 1'b0);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("fill_overflow", overflow, 1'b1);
    wait_idle(9 * 10 * C + 50, "fill_drain_timeout");
    chk("fill_rx_count", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (rx_q.size() > 0) chk($sformatf("fill_rx_%0d", i), rx_q.pop_front(), 7'h30 + 7'(i));
    end
    rx_q.delete();

    // Back-to-back frames
    put(7'h41);
    put(7'h42);
    in_valid = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 81; i++) begin
      @(negedge clk);
      if (i == 10 * C - 1) chk("b2b_last_stop_high", tx, 1'b1);
      if (i == 10 * C) chk("b2b_start_follows_stop", tx, 1'b0);
      if (i < 80 && busy) bcnt++;
      if (i == 80) chk("b2b_busy_falls", busy, 1'b0);
    end
    chk("b2b_busy_cycles", bcnt, 80);
    chk("b2b_rx_count", rx_q.size(), 2);
    if (rx_q.size() > 1) begin
      chk("b2b_rx_0", rx_q.pop_front(), 7'h41);
      chk("b2b_rx_1", rx_q.pop_front(), 7'h42);
    end
    rx_q.delete();

    // Reset during data bit 3 with two characters queued
    put(7'h51);
    put(7'h52);
    put(7'h53);
    in_valid = 1'b0;
    chk("midrst_queued", fifo_count, 4'd2);
    repeat (17) @(negedge clk);
    chk("midrst_bit3_level", tx, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_tx_async", tx, 1'b1);
    chk("midrst_count_async", fifo_count, 4'd0);
    chk("midrst_busy_async", busy, 1'b0);
    rx_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("midrst_after_busy", busy, 1'b0);
    chk("midrst_after_rx", rx_q.size(), 0);
    chk("midrst_after_ovf", overflow, 1'b0);

    // Pointer wrap: 20 random characters in bursts of 5
    exp_q.delete();
    rx_q.delete();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 5; i++) begin
        d = 7'($urandom_range(0, 127));
        exp_q.push_back(d);
        put(d);
      end
      in_valid = 1'b0;
      wait_idle(6 * 10 * C + 50, "wrap_drain_timeout");
    end
    chk("wrap_rx_count", rx_q.size(), 20);
    for (int i = 0; i < 20; i++) begin
      if (rx_q.size() > 0 && exp_q.size() > 0)
        chk($sformatf("wrap_rx_%0d", i), rx_q.pop_front(), exp_q.pop_front());
    end
    chk("wrap_overflow", overflow, 1'b0);

    // Random traffic against the model
    rx_q.delete();
    m_acc.delete();
    for (int i = 0; i < 800; i++) begin
      data_in  = 7'($urandom_range(0, 127));
      in_valid = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle(D * 10 * C + 80, "rand_drain_timeout");
    chk("rand_rx_count", rx_q.size(), m_acc.size());
    while (rx_q.size() > 0 && m_acc.size() > 0)
      chk("rand_rx_char", rx_q.pop_front(), m_acc.pop_front());

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_uart_tx.md
# text_uart_tx

Downstream output stage for the text link. Accepts decrypted 7-bit characters from the decrypt stage through a valid/ready handshake and buffers them in a small FIFO. Each character is serialised onto a UART line, LSB first, in a fixed 10-bit frame. The block is the last stage before the board's serial pin and isolates the per-cycle decrypt output from the much slower line rate.

## Interface
- n, 7, character width in bits; the frame is fixed at 10 bits, so only n=7 is supported
- DEPTH, 8, FIFO depth in characters; must be a power of 2, ≥2
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be ≥2
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- data_in  input  n  character from decrypt stage
- in_valid  input  1  data_in holds a character this cycle
- in_ready  output  1  FIFO can accept a character; equals fifo_count < DEPTH
- tx  output  1  UART line, idles high, registered
- busy  output  1  a frame is in progress (FSM not IDLE)
- fifo_count  output  log2(DEPTH)+1  characters currently buffered
- overflow  output  1  sticky: set when in_valid=1 while in_ready=0; cleared only by reset

## Operation
- Write: the FIFO pushes data_in on the edge where in_valid && in_ready.
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- Pop: the FSM pops the head character into the shift register when it needs a new frame and fifo_count>0.
- A simultaneous push and pop leaves fifo_count unchanged.
- in_ready depends only on the registered count. When full, a write is refused even if a pop happens the same cycle.
- Frame on tx: start bit (0), data[0]..data[6], bit 8, stop bit (1).
  - Bit 8 is 0 without TEXT_PARITY_EN.
  - Bit 8 is even parity (^data) with TEXT_PARITY_EN.
- FSM states and transitions:
  - IDLE: tx=1. Go to START with a pop if count>0.
  - START: tx=0.
  - DATA: 8 bits, including bit 8.
  - STOP: tx=1.
  - At the end of STOP: if count>0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 in each non-IDLE state. The state or bit index advances when it reaches CLKS_PER_BIT-1.
- A bit index of 0..7 selects the DATA bit.
- Reset mid-operation: FIFO empties, the frame is abandoned and tx returns to 1 immediately (asynchronously).

## Timing
- Reset values:
  - tx=1, busy=0, in_ready=1, fifo_count=0, overflow=0.
  - FSM=IDLE; baud counter, bit index and pointers all 0.
- Write at edge k into an empty FIFO with the FSM idle:
  - fifo_count=1 after edge k.
  - Pop at edge k+1: tx=0, busy=1, count returns to 0.
- Each bit lasts exactly CLKS_PER_BIT cycles. A frame is 10·CLKS_PER_BIT cycles.
- busy falls on the edge that ends STOP, unless back-to-back.
- Back-to-back frames: the stop bit is followed immediately by the next start bit, with busy held high.
- overflow sets on the edge after the refused write attempt.

## Configuration
- TEXT_PARITY_EN defined: bit 8 of every frame is even parity over data[6:0], i.e. 7E1 framing.
- Not defined: bit 8 is constant 0, i.e. 8N1 with MSB 0.
- Frame length and all timing are identical in both builds.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release -> tx=1, busy=0, in_ready=1, fifo_count=0, overflow=0; tx stays 1 for 100 idle cycles.
- Single char, CLKS_PER_BIT=4, data_in=0x43 -> from the edge after the write, tx holds each of 0,1,1,0,0,0,0,1,b8,1 for 4 cycles. b8=0 without TEXT_PARITY_EN and b8=1 with it. busy is high for exactly 40 cycles.
- Fill: FSM idle, in_valid=1 for 10 consecutive cycles with data 0x30..0x39:
  - First 9 accepted (first popped immediately), fifo_count=8, in_ready=0 on the 10th, overflow=1.
  - Lines out carry 0x30..0x38 in order; 0x39 is never sent.
- Back-to-back: write 0x41 and 0x42 on consecutive cycles -> 20·CLKS_PER_BIT cycles of continuous frames. tx is low the cycle after the first stop bit ends, and busy never drops between frames.
- Reset mid-frame: assert rst=0 during data bit 3 with 2 chars queued -> tx=1 and fifo_count=0 without waiting for a clk edge. After release, the FSM is IDLE and nothing is transmitted.
- Wrap: DEPTH=8, push and drain 20 chars in bursts of 5 -> output order matches input across pointer wrap, and overflow stays 0.
